// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Synchronizes an asynchronous active-low reset, holds every downstream
//   stage in reset for HOLD_CYCLES, then releases stages one at a time in
//   index order. Each release waits for that stage's acknowledge followed by
//   GAP_CYCLES before the next stage is released.
//
// Ports
//   receiving_clock  sequencer clock; all outputs are synchronous to it
//   reset_in         asynchronous active-low reset (driven from a register)
//   sw_reset_req     single-cycle request to re-run the whole sequence
//   stage_ack        per-stage "initialized" level
//   stage_reset_n    per-stage active-low resets
//   seq_done         all stages released and acknowledged
//   busy             inverse of seq_done
//   seq_error        sticky acknowledge-timeout flag
//   current_stage    stage being released/awaited; STAGES when done
//
// Build option
//   RESET_SEQUENCER_TIMEOUT_EN : when defined, each acknowledge wait is
//   bounded by ACK_TIMEOUT cycles; expiry sets seq_error and the sequence
//   carries on as if the acknowledge had arrived. When undefined, the wait is
//   unbounded and seq_error is tied low.
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int EXTRA_DEPTH = 0,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                     receiving_clock,
  input  logic                     reset_in,
  input  logic                     sw_reset_req,
  input  logic [STAGES-1:0]        stage_ack,
  output logic [STAGES-1:0]        stage_reset_n,
  output logic                     seq_done,
  output logic                     busy,
  output logic                     seq_error,
  output logic [$clog2(STAGES):0]  current_stage
);

  localparam int SYNC_DEPTH = 2 + EXTRA_DEPTH;
  localparam int SW         = $clog2(STAGES) + 1;
  localparam int MAX_HG     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_CNT    = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW         = $clog2(MAX_CNT + 1);

  // Out-of-range parameters stop elaboration.
  if (STAGES < 1 || STAGES > 16 || EXTRA_DEPTH < 0 || HOLD_CYCLES < 1 ||
      GAP_CYCLES < 1 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("reset_sequencer: parameter out of range");
  end

  // ---------------------------------------------------------------------
  // Reset synchronizer: asynchronous assert, synchronous release.
  // ---------------------------------------------------------------------
  (* ASYNC_REG = "TRUE", IOB = "FALSE", DONT_TOUCH = "TRUE", preserve *)
  logic [SYNC_DEPTH-1:0] sync_ff;
  logic                  sync_rst_n;

  always_ff @(posedge receiving_clock or negedge reset_in) begin
    if (!reset_in) sync_ff <= '0;
    else           sync_ff <= {sync_ff[SYNC_DEPTH-2:0], 1'b1};
  end

  assign sync_rst_n = sync_ff[SYNC_DEPTH-1];

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_dec;
  logic [SW-1:0]     cur_q, cur_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              ack_sel;
  logic              advance;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
  logic              err_q, err_d;
`endif

  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - CW'(1);

  // Acknowledge of the stage currently awaited; all other bits are ignored.
  always_comb begin
    ack_sel = 1'b0;
    for (int k = 0; k < STAGES; k++)
      if (cur_q == SW'(k)) ack_sel = stage_ack[k];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    rst_d   = rst_q;
    done_d  = done_q;
    advance = 1'b0;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
    err_d   = err_q;
`endif
    if (sw_reset_req) begin
      // Restart wins over any simultaneous ack or counter expiry;
      // the error flag deliberately survives a software restart.
      state_d = HOLD;
      cnt_d   = CW'(HOLD_CYCLES);
      cur_d   = '0;
      rst_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          cnt_d = cnt_dec;
          if (cnt_q <= CW'(1)) state_d = RELEASE;
        end
        RELEASE: begin
          for (int k = 0; k < STAGES; k++)
            if (cur_q == SW'(k)) rst_d[k] = 1'b1;
          state_d = WAIT_ACK;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          cnt_d   = CW'(ACK_TIMEOUT);
`endif
        end
        WAIT_ACK: begin
          if (ack_sel) begin
            advance = 1'b1;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          end else if (cnt_q <= CW'(1)) begin
            advance = 1'b1;
            err_d   = 1'b1;
          end else begin
            cnt_d   = cnt_dec;
`endif
          end
          if (advance) begin
            if (cur_q == SW'(STAGES - 1)) begin
              state_d = DONE;
              cur_d   = SW'(STAGES);
              done_d  = 1'b1;
            end else begin
              cur_d = cur_q + SW'(1);
              // The ack edge counts as the first gap cycle and RELEASE as
              // the last, so GAP itself lasts GAP_CYCLES-1 cycles.
              if (GAP_CYCLES == 1) begin
                state_d = RELEASE;
              end else begin
                state_d = GAP;
                cnt_d   = CW'(GAP_CYCLES - 1);
              end
            end
          end
        end
        GAP: begin
          cnt_d = cnt_dec;
          if (cnt_q <= CW'(1)) state_d = RELEASE;
        end
        DONE: ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge receiving_clock or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q <= HOLD;
      cnt_q   <= CW'(HOLD_CYCLES);
      cur_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

`ifdef RESET_SEQUENCER_TIMEOUT_EN
  always_ff @(posedge receiving_clock or negedge sync_rst_n) begin
    if (!sync_rst_n) err_q <= 1'b0;
    else             err_q <= err_d;
  end
  assign seq_error = err_q;
`else
  assign seq_error = 1'b0;
`endif

  assign stage_reset_n = rst_q;
  assign seq_done      = done_q;
  assign busy          = ~done_q;
  assign current_stage = cur_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Checks reset_sequencer against an edge-numbered behavioural model: every
//   release is scheduled as an absolute edge number, and acknowledges are
//   looked up only for the awaited stage. Directed scenarios pin the model
//   with hand-computed literals, then a randomized phase runs the compare.
module tb_reset_sequencer;
  localparam int S    = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int XD   = 0;
  localparam int TMO  = 8;
  localparam int SD   = 2 + XD;

  logic                 clk = 1'b0;
  logic                 rst_in = 1'b0;
  logic                 sw = 1'b0;
  logic [S-1:0]         ack = '0;
  logic [S-1:0]         srn;
  logic                 done, busy, err;
  logic [$clog2(S):0]   cur;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .STAGES(S), .EXTRA_DEPTH(XD), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)
  ) dut (
    .receiving_clock(clk), .reset_in(rst_in), .sw_reset_req(sw),
    .stage_ack(ack), .stage_reset_n(srn), .seq_done(done), .busy(busy),
    .seq_error(err), .current_stage(cur)
  );

  // Posedges happen at 10n+5; this returns n for the latest posedge.
  function automatic int ecnt();
    return int'(($time - 5) / 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h edge=%0d", name, act, exp, ecnt());
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_sync = 0;      // synchronizer edges seen since reset_in rose
  int m_rel = 0;       // number of stages released
  int m_cur = 0;
  int m_rel_at = -1;   // edge at which the next release happens (-1: awaiting ack)
  int m_wait = -1;     // edge at which the awaited stage was released
  bit m_done = 0;
  bit m_err = 0;

  always @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      m_sync = 0; m_rel = 0; m_cur = 0; m_rel_at = -1; m_wait = -1;
      m_done = 0; m_err = 0;
    end else if (m_sync < SD) begin
      m_sync++;
      if (m_sync == SD) m_rel_at = ecnt() + 1 + HOLD;
    end else begin
      int n;
      bit go;
      n = ecnt();
      go = 0;
      if (sw) begin
        m_rel = 0; m_cur = 0; m_done = 0; m_wait = -1;
        m_rel_at = n + 1 + HOLD;
      end else if (!m_done) begin
        if (m_rel_at == n) begin
          m_rel = m_cur + 1;
          m_rel_at = -1;
          m_wait = n;
        end else if (m_rel_at == -1 && m_wait >= 0 && n > m_wait) begin
          if (ack[m_cur]) go = 1;
`ifdef RESET_SEQUENCER_TIMEOUT_EN
          else if (n == m_wait + TMO) begin go = 1; m_err = 1; end
`endif
          if (go) begin
            m_wait = -1;
            if (m_cur == S - 1) begin m_done = 1; m_cur = S; end
            else begin m_cur++; m_rel_at = n + GAP; end
          end
        end
      end
    end
  end

  function automatic logic [S-1:0] mmask();
    logic [S-1:0] r;
    for (int k = 0; k < S; k++) r[k] = (k < m_rel);
    return r;
  endfunction

  // Per-cycle compare against the model, on the falling edge.
  always @(negedge clk) begin
    chk("model_outputs",
        {20'd0, srn, done, busy, err, 5'(cur)},
        {20'd0, mmask(), m_done, !m_done, m_err, 5'(m_cur)});
  end

  // ---------------- directed helpers ----------------
  task automatic wait_neg(input int n);
    while (ecnt() < n || clk) @(negedge clk);
  endtask

  // Releases reset_in between edges; returns E, the first FSM edge.
  task automatic release_rst(output int e);
    #2 rst_in = 1'b1;
    e = ecnt() + 1 + SD;
  endtask

  // Literal timing with all acks high, E = first running edge.
  task automatic seq1(input int e, input bit chk_rst);
    if (chk_rst) begin
      wait_neg(e - 1);
      chk("rst_srn", 32'(srn), 32'h0);
      chk("rst_busy", 32'(busy), 32'h1);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_cur", 32'(cur), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
    end
    wait_neg(e + 3);  chk("s1_e3", 32'(srn), 32'h0);
    wait_neg(e + 4);  chk("s1_e4", 32'(srn), 32'h1);
    wait_neg(e + 6);  chk("s1_e6", 32'(srn), 32'h1);
    wait_neg(e + 7);  chk("s1_e7", 32'(srn), 32'h3);
    wait_neg(e + 9);  chk("s1_e9", 32'(srn), 32'h3);
    wait_neg(e + 10); chk("s1_e10", 32'(srn), 32'h7);
    chk("s1_e10_done", 32'(done), 32'h0);
    wait_neg(e + 11);
    chk("s1_e11_done", 32'(done), 32'h1);
    chk("s1_e11_busy", 32'(busy), 32'h0);
    chk("s1_e11_cur", 32'(cur), 32'h3);
  endtask

  task automatic pulse_rst(input int cycles);
    @(negedge clk);
    #2 rst_in = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int e, a, s;
    // Scenario 1: all acks high from reset.
    ack = '1;
    wait_neg(2);
    release_rst(e);
    seq1(e, 1);

`ifdef RESET_SEQUENCER_TIMEOUT_EN
    // Acknowledge never arrives for stage 0: timeout after TMO edges.
    pulse_rst(2);
    ack = '0;
    release_rst(e);
    wait_neg(e + 4);            chk("to_rel0", 32'(srn), 32'h1);
    wait_neg(e + 4 + TMO - 1);  chk("to_err_pre", 32'(err), 32'h0);
    wait_neg(e + 4 + TMO);      chk("to_err", 32'(err), 32'h1);
    wait_neg(e + 4 + TMO + 1);  chk("to_rel1_pre", 32'(srn), 32'h1);
    wait_neg(e + 4 + TMO + 2);  chk("to_rel1", 32'(srn), 32'h3);
    ack = '1;
    wait_neg(e + 40);
    chk("to_done", 32'(done), 32'h1);
    chk("to_err_sticky", 32'(err), 32'h1);
`else
    // Scenario 2: stage 1 acknowledge withheld.
    pulse_rst(2);
    ack = 3'b001;
    release_rst(e);
    wait_neg(e + 57);
    chk("s2_srn", 32'(srn), 32'h3);
    chk("s2_busy", 32'(busy), 32'h1);
    chk("s2_cur", 32'(cur), 32'h1);
    ack = 3'b110;               // ack[0] drops: no effect
    a = ecnt() + 1;
    wait_neg(a + 1); chk("s2_a1", 32'(srn), 32'h3);
    wait_neg(a + 2); chk("s2_a2", 32'(srn), 32'h7);
    wait_neg(a + 3); chk("s2_done", 32'(done), 32'h1);
`endif

    // Scenario 3: reset_in pulled low mid-gap, asynchronous clear.
    pulse_rst(2);
    ack = '1;
    release_rst(e);
    wait_neg(e + 5);
    #2 rst_in = 1'b0;
    #1;
    chk("s3_async_srn", 32'(srn), 32'h0);
    chk("s3_async_done", 32'(done), 32'h0);
    chk("s3_async_busy", 32'(busy), 32'h1);
    wait_neg(e + 7);
    release_rst(e);
    seq1(e, 1);

    // Scenario 4: software restart in DONE with ack high.
    sw = 1'b1;
    s = ecnt() + 1;
    wait_neg(s);
    sw = 1'b0;
    chk("s4_srn", 32'(srn), 32'h0);
    chk("s4_busy", 32'(busy), 32'h1);
    chk("s4_cur", 32'(cur), 32'h0);
    seq1(s + 1, 0);

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ack = S'($urandom) & S'($urandom);
      sw  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        sw = 1'b0;
        #2 rst_in = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #2 rst_in = 1'b1;
      end
    end
    sw = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
